// File: rtl/can_rx_frame_fetch.sv
// Fetches received CAN frames (DLC/flags, DATA0, DATA1, then ID) from the core into a
// DEPTH-entry FIFO; CPU register accesses pass through to the core while the engine is idle.
module can_rx_frame_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic [1:0]    cpu_rs,
  input  logic [3:0]    cpu_bytesel,
  input  logic [31:0]   cpu_d,
  output logic [31:0]   cpu_q,
  output logic          cpu_ready,
  output logic          can_cs,
  output logic [1:0]    can_rs,
  output logic [3:0]    can_bytesel,
  output logic [31:0]   can_d,
  input  logic [31:0]   can_q,
  input  logic          can_irqrx,
  output logic          rx_valid,
  input  logic          rx_pop,
  output logic [31:0]   rx_id,
  output logic [15:0]   rx_dlcf,
  output logic [31:0]   rx_data0,
  output logic [31:0]   rx_data1,
  output logic [AW:0]   rx_count,
  output logic          rx_ovf,
  input  logic          ovf_clr
);

  typedef enum logic [2:0] {IDLE, F_DLCF, F_D0, F_D1, F_ID, COMMIT, SETTLE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [15:0]   dlcf_q, dlcf_d;
  logic [31:0]   d0_q, d0_d, d1_q, d1_d, id_q, id_d;
  logic [31:0]   mem_id_q [DEPTH];
  logic [15:0]   mem_dlcf_q [DEPTH];
  logic [31:0]   mem_d0_q [DEPTH];
  logic [31:0]   mem_d1_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop_en, push_en, drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A CPU access in the same cycle as the interrupt is served first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (can_irqrx && !cpu_cs) state_d = F_DLCF;
      F_DLCF:  state_d = F_D0;
      F_D0:    state_d = F_D1;
      F_D1:    state_d = F_ID;
      F_ID:    state_d = COMMIT;
      COMMIT:  state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready   = 1'b0;
    can_cs      = 1'b0;
    can_rs      = 2'd0;
    can_bytesel = 4'b0000;
    can_d       = 32'd0;
    case (state_q)
      IDLE: begin
        cpu_ready   = 1'b1;
        can_cs      = cpu_cs;
        can_rs      = cpu_rs;
        can_bytesel = cpu_bytesel;
        can_d       = cpu_d;
      end
      F_DLCF:  begin can_cs = 1'b1; can_rs = 2'd1; end
      F_D0:    begin can_cs = 1'b1; can_rs = 2'd2; end
      F_D1:    begin can_cs = 1'b1; can_rs = 2'd3; end
      F_ID:    begin can_cs = 1'b1; can_rs = 2'd0; end
      default: ;
    endcase
  end

  assign cpu_q = can_q;

  always_comb begin
    dlcf_d = (state_q == F_DLCF) ? can_q[15:0] : dlcf_q;
    d0_d   = (state_q == F_D0)   ? can_q       : d0_q;
    d1_d   = (state_q == F_D1)   ? can_q       : d1_q;
    id_d   = (state_q == F_ID)   ? can_q       : id_q;
  end

  // When full, a pop in the commit cycle frees the slot the new frame takes.
  assign pop_en  = rx_pop && (count_q != '0);
  assign push_en = (state_q == COMMIT) && ((count_q != FULL_CNT) || rx_pop);
  assign drop    = (state_q == COMMIT) && !push_en;

  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_en && !pop_en)      count_d = count_q + (AW+1)'(1);
    else if (!push_en && pop_en) count_d = count_q - (AW+1)'(1);
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dlcf_q   <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id_q[i]   <= '0;
        mem_dlcf_q[i] <= '0;
        mem_d0_q[i]   <= '0;
        mem_d1_q[i]   <= '0;
      end
    end else begin
      dlcf_q   <= dlcf_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push_en) begin
        mem_id_q[wr_ptr_q]   <= id_q;
        mem_dlcf_q[wr_ptr_q] <= dlcf_q;
        mem_d0_q[wr_ptr_q]   <= d0_q;
        mem_d1_q[wr_ptr_q]   <= d1_q;
      end
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;
  assign rx_ovf   = ovf_q;
  assign rx_id    = mem_id_q[rd_ptr_q];
  assign rx_dlcf  = mem_dlcf_q[rd_ptr_q];
  assign rx_data0 = mem_d0_q[rd_ptr_q];
  assign rx_data1 = mem_d1_q[rd_ptr_q];

endmodule
